// File: rtl/cic_integrator_decim_pkg.sv
// rtl/cic_integrator_decim_pkg.sv - shared sizing helpers for the CIC integrator and comb chains
package cic_integrator_decim_pkg;

    // Smallest n with 2**n >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width that keeps the full integrate/comb chain exact.
    function automatic int min_acc_width(input int in_width, input int stages, input int decimation);
        return in_width + stages * clog2(decimation);
    endfunction

endpackage

// File: rtl/cic_integrator_decim_if.sv
// rtl/cic_integrator_decim_if.sv - sample stream in, decimated stream out
interface cic_integrator_decim_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 64
);
    logic                 in_strobe;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_strobe;
    logic [ACC_WIDTH-1:0] out_data;

    modport master (
        output in_strobe,
        output in_data,
        input  out_strobe,
        input  out_data
    );

    modport slave (
        input  in_strobe,
        input  in_data,
        output out_strobe,
        output out_data
    );
endinterface

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - one strobe-enabled modulo-2^WIDTH accumulator
module cic_integrator #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/cic_integrator_decim.sv
// rtl/cic_integrator_decim.sv - cascaded integrators with every DECIMATION-th value strobed out
module cic_integrator_decim
    import cic_integrator_decim_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int DECIMATION = 40,
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    cic_integrator_decim_if.slave  bus
);

    localparam int CNT_W = clog2(DECIMATION);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

    logic [ACC_WIDTH-1:0] sample_ext;
    logic [ACC_WIDTH-1:0] acc [STAGES];
    logic [ACC_WIDTH-1:0] last_next;
    logic [CNT_W-1:0]     count;
    logic                 strobe_q;
    logic [ACC_WIDTH-1:0] data_q;

    // Size cast of a signed operand sign-extends (or wraps when ACC_WIDTH is narrower).
    assign sample_ext = ACC_WIDTH'($signed(bus.in_data));

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [ACC_WIDTH-1:0] addend;

        if (k == 0) begin : g_first
            assign addend = sample_ext;
        end else begin : g_chain
            assign addend = acc[k-1];
        end

        // The value the last stage is about to take, so the output needs no extra cycle.
        if (k == STAGES - 1) begin : g_last
            assign last_next = acc[k] + addend;
        end

        cic_integrator #(.WIDTH(ACC_WIDTH)) u_int (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (bus.in_strobe),
            .addend  (addend),
            .acc     (acc[k])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else if (bus.in_strobe) begin
            if (count == CNT_LAST) begin
                count    <= '0;
                strobe_q <= 1'b1;
                data_q   <= last_next;
            end else begin
                count    <= count + CNT_W'(1);
                strobe_q <= 1'b0;
            end
        end else begin
            strobe_q <= 1'b0;
        end
    end

    assign bus.out_strobe = strobe_q;
    assign bus.out_data   = data_q;

endmodule

// File: tb/tb_cic_integrator_decim.sv
// tb/tb_cic_integrator_decim.sv - four CIC integrator configurations against a binomial-sum model
module tb_cic_integrator_decim;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_strobe;
    logic [15:0] in_data;

    always #5 clock = ~clock;

    localparam int NS [4] = '{1, 3, 1, 1};
    localparam int ND [4] = '{4, 4, 4, 40};
    localparam int NW [4] = '{64, 64, 8, 64};
    localparam longint MISSING = 64'sh7eadbeef_0badf00d;

    cic_integrator_decim_if #(.IN_WIDTH(16), .ACC_WIDTH(64)) if0 ();
    cic_integrator_decim_if #(.IN_WIDTH(16), .ACC_WIDTH(64)) if1 ();
    cic_integrator_decim_if #(.IN_WIDTH(16), .ACC_WIDTH(8))  if2 ();
    cic_integrator_decim_if #(.IN_WIDTH(16), .ACC_WIDTH(64)) if3 ();

    assign if0.in_strobe = in_strobe;
    assign if1.in_strobe = in_strobe;
    assign if2.in_strobe = in_strobe;
    assign if3.in_strobe = in_strobe;
    assign if0.in_data   = in_data;
    assign if1.in_data   = in_data;
    assign if2.in_data   = in_data;
    assign if3.in_data   = in_data;

    cic_integrator_decim #(.STAGES(1), .DECIMATION(4), .IN_WIDTH(16), .ACC_WIDTH(64)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(if0.slave));
    cic_integrator_decim #(.STAGES(3), .DECIMATION(4), .IN_WIDTH(16), .ACC_WIDTH(64)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(if1.slave));
    cic_integrator_decim #(.STAGES(1), .DECIMATION(4), .IN_WIDTH(16), .ACC_WIDTH(8)) u2 (
        .clock(clock), .reset_n(reset_n), .bus(if2.slave));
    cic_integrator_decim #(.STAGES(1), .DECIMATION(40), .IN_WIDTH(16), .ACC_WIDTH(64)) u3 (
        .clock(clock), .reset_n(reset_n), .bus(if3.slave));

    logic   os [4];
    longint od [4];
    assign os[0] = if0.out_strobe;
    assign os[1] = if1.out_strobe;
    assign os[2] = if2.out_strobe;
    assign os[3] = if3.out_strobe;
    assign od[0] = longint'($signed(if0.out_data));
    assign od[1] = longint'($signed(if1.out_data));
    assign od[2] = longint'($signed(if2.out_data));
    assign od[3] = longint'($signed(if3.out_data));

    int     tests = 0;
    int     fails = 0;
    bit     mon_en = 1'b0;
    longint hist[$];
    int     nacc = 0;
    bit     just_acc = 1'b0;
    longint exp_d [4] = '{0, 0, 0, 0};
    longint outq [4][$];

    function automatic longint binom(input int a, input int b);
        longint r;
        r = 1;
        if (a < b) return 0;
        for (int i = 1; i <= b; i++) r = r * longint'(a - b + i) / longint'(i);
        return r;
    endfunction

    function automatic longint sext(input longint v, input int w);
        if (w >= 64) return v;
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // S cascaded running sums of x equal a convolution with binomial weights C(n-j, S-1).
    function automatic longint model(input int s, input int w);
        longint acc;
        int     n;
        acc = 0;
        n = hist.size() - 1;
        for (int j = 0; j <= n; j++) acc += hist[j] * binom(n - j, s - 1);
        return sext(acc, w);
    endfunction

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, d, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (reset_n === 1'b1 && in_strobe === 1'b1) begin
            hist.push_back(longint'($signed(in_data)));
            nacc++;
            just_acc = 1'b1;
        end else begin
            just_acc = 1'b0;
        end
    end

    always @(negedge clock) begin
        bit es;
        if (mon_en) begin
            for (int d = 0; d < 4; d++) begin
                es = just_acc && (nacc % ND[d] == 0);
                if (es) exp_d[d] = model(NS[d], NW[d]);
                chk("out_strobe", d, longint'(os[d]), longint'(es));
                chk("out_data", d, od[d], exp_d[d]);
                if (os[d] === 1'b1) outq[d].push_back(od[d]);
            end
        end
    end

    task automatic idle(input int n);
        in_strobe = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic [15:0] v);
        in_strobe = 1'b1;
        in_data   = v;
        @(posedge clock);
        #1;
        in_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_strobe = 1'b0;
        hist.delete();
        nacc     = 0;
        just_acc = 1'b0;
        for (int d = 0; d < 4; d++) begin
            exp_d[d] = 0;
            outq[d].delete();
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        string       name;
        int          dut;
        logic [15:0] first;
        logic [15:0] rest;
        int          nsamp;
        bit          gaps;
        int          nexp;
        longint      exp [5];
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{"const1",       0, 16'd1,      16'd1,      16,  1'b0, 4, '{4, 8, 12, 16, 0}};
        tbl[1] = '{"impulse",      1, 16'd1,      16'd0,      8,   1'b0, 2, '{3, 21, 0, 0, 0}};
        tbl[2] = '{"wrap8",        2, 16'd7,      16'd7,      20,  1'b0, 5, '{28, 56, 84, 112, -116}};
        tbl[3] = '{"negfs",        3, 16'h8000,   16'h8000,   120, 1'b0, 3, '{-1310720, -2621440, -3932160, 0, 0}};
        tbl[4] = '{"impulse_gaps", 1, 16'd1,      16'd0,      8,   1'b1, 2, '{3, 21, 0, 0, 0}};
        tbl[5] = '{"const_neg3",   0, 16'hfffd,   16'hfffd,   16,  1'b1, 4, '{-12, -24, -36, -48, 0}};

        reset_n   = 1'b0;
        in_strobe = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clock);
        #1;
        mon_en = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int s = 0; s < tbl[i].nsamp; s++) begin
                if (tbl[i].gaps) idle($urandom_range(2, 6));
                drive(s == 0 ? tbl[i].first : tbl[i].rest);
            end
            idle(3);
            chk({tbl[i].name, "_count"}, tbl[i].dut, longint'(outq[tbl[i].dut].size()), longint'(tbl[i].nexp));
            for (int k = 0; k < tbl[i].nexp; k++) begin
                chk(tbl[i].name, tbl[i].dut,
                    (k < outq[tbl[i].dut].size()) ? outq[tbl[i].dut][k] : MISSING,
                    tbl[i].exp[k]);
            end
        end

        // Reset asserted mid-accumulation, then a fresh constant-1 run.
        do_reset();
        repeat (3) drive(16'd1);
        do_reset();
        idle(2);
        chk("reset_no_output", 0, longint'(outq[0].size()), 0);
        repeat (4) drive(16'd1);
        idle(2);
        chk("restart_count", 0, longint'(outq[0].size()), 1);
        chk("restart_first", 0, (outq[0].size() > 0) ? outq[0][0] : MISSING, 4);

        // Random data with random gaps; the negedge monitor checks every cycle.
        do_reset();
        for (int s = 0; s < 240; s++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            drive(16'($urandom));
        end
        idle(3);
        chk("random_count_d40", 3, longint'(outq[3].size()), 6);
        chk("random_count_d4", 1, longint'(outq[1].size()), 60);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cic_integrator_decim.md
# cic_integrator_decim

- Integrator-and-decimate front half of the CIC decimation filter.
- Accepts input samples at the high rate, qualified by `in_strobe`, and runs them through a cascade of STAGES integrators.
- Emits every DECIMATION-th integrated value with a one-clock `out_strobe`.
- Sits directly upstream of the comb chain: `out_strobe`/`out_data` drive the `strobe`/`in_data` of the first comb stage.

## Interface
- STAGES, 3: number of cascaded integrators (1..8).
- DECIMATION, 40: input samples per output sample (2..4096).
- IN_WIDTH, 16: signed input sample width.
- ACC_WIDTH, 64: integrator/output width; must be ≥ IN_WIDTH + STAGES·ceil(log2(DECIMATION)) for exact results after the combs.
- clock  in  1  single system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_strobe  in  1  input sample valid, one clock per sample, arbitrary gaps allowed.
- in_data  in  IN_WIDTH  signed input sample, sampled when in_strobe=1.
- out_strobe  out  1  one-clock pulse, output sample valid.
- out_data  out  ACC_WIDTH  signed decimated integrator value, held between strobes.

## Operation
- Reset (reset_n=0, asynchronous): all integrators, the decimation counter, out_strobe and out_data go to 0. They stay 0 until the first in_strobe after release.
- Input is sign-extended to ACC_WIDTH. All arithmetic is two's-complement modulo 2^ACC_WIDTH:
  - wrap-around is required behaviour;
  - no saturation;
  - no overflow flag.
- On a clock with in_strobe=1, every integrator updates simultaneously using pre-edge values:
  - int[0] <= int[0] + ext(in_data);
  - int[k] <= int[k] + int[k-1] for k = 1..STAGES-1.
- On a clock with in_strobe=0, the integrators and the counter hold.
- The decimation counter counts accepted samples through 0..DECIMATION-1:
  - When in_strobe=1 and count = DECIMATION-1: count <= 0, out_strobe <= 1, and out_data <= the value being written into int[STAGES-1] on that same edge.
  - When in_strobe=1 and count < DECIMATION-1: count <= count+1, out_strobe <= 0.
  - When in_strobe=0: out_strobe <= 0.
- out_data changes only on the edge that sets out_strobe.
- Downstream combs rely on out_strobe never being high on two consecutive clocks. This holds whenever DECIMATION ≥ 2.
- No flush or clear input. Resynchronisation is done only via reset_n.

## Timing
- Latency: out_strobe and out_data are valid 1 clock after the edge that accepts the DECIMATION-th sample.
- Pulse width: out_strobe is exactly 1 clock wide.
- Data path: because each integrator adds its predecessor's pre-edge value, integrator k lags the input by k samples.
- Throughput: in_strobe may be high every clock (full rate). It may also be high 1 clock in N with any gap pattern; the output depends only on the sample sequence, not on the gaps.
- Reset asserted mid-accumulation clears state immediately, with no pending out_strobe. The first output after release comes after DECIMATION new samples.
- Reset released on the same edge as an in_strobe: that sample may be dropped. Benches must not rely on it.

## Structure
- Shared package/header `cic_defs`:
  - clog2 function;
  - minimum-ACC_WIDTH computation, used by top level and bench to size the integrator and comb chains consistently.
- Sub-module `cic_integrator` (WIDTH parameter): one registered accumulator with strobe enable and async active-low reset, generated STAGES times.
- Counter width: clog2(DECIMATION), local to this block.

## Test plan
- Constant input: STAGES=1, DECIMATION=4, in_data=1 every clock → out_data 4, 8, 12, 16; out_strobe every 4th accepted sample, 1 clock after it.
- Impulse: STAGES=3, DECIMATION=4, in_data=1 at sample 0, then 0 → int[2] sequence 0,0,1,3,6,10,15,21; outputs 3 (after sample 3) and 21 (after sample 7).
- Wrap-around: STAGES=1, DECIMATION=4, ACC_WIDTH=8, in_data=+7 → outputs 28, 56, 84, 112, then -116 (140 mod 256).
- Strobe gaps: repeat the impulse test with in_strobe high 1 clock in 5, randomly jittered → identical out_data sequence, with out_strobe 1 clock after each 4th sample.
- Reset mid-operation: reset_n low for 1 clock after sample 2 → out_strobe stays 0, all state reads 0. Restarting the constant-1 test then yields 4 after 4 new samples.
- Negative full-scale: IN_WIDTH=16, in_data=-32768 constant, STAGES=1, DECIMATION=40, ACC_WIDTH=64 → out_data = -1310720·n, exact sign extension.
